uart_tx_buffered: RTL and testbench

//  Buffered, frame-configurable UART transmitter; successor to the single-byte uart_tx.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_fifo.sv | 63 ++++++
 rtl/uart_tx_buffered.sv | 188 ++++++++++++++++++
 tb/tb_uart_tx_buffered.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit (and future receive) path.
//   PARITY_NONE/EVEN/ODD : values for the PARITY parameter
//   tx_state_t           : transmitter FSM states
//   clog2()              : ceiling log2 for sizing counters and pointers
//   baud_divisor()       : clocks per bit period
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_EVEN = 1;
   localparam int unsigned PARITY_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      for (int unsigned span = 1; span < value; span = span * 2) begin
         result = result + 1;
      end
      return result;
   endfunction

   function automatic int unsigned baud_divisor(input int unsigned clock_freq,
                                                input int unsigned baud_rate);
      return clock_freq / baud_rate;
   endfunction

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO, one clock, registered full/empty flags.
//   clock     in   rising-edge clock
//   reset     in   asynchronous, active-low; empties the FIFO
//   push      in   write strobe, ignored while full
//   push_data in   WIDTH word to store
//   pop       in   read strobe, ignored while empty
//   pop_data  out  word at the head (valid while !empty)
//   full      out  no free entry
//   empty     out  no stored entry
module uart_fifo
   import uart_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      wr_nxt;
   logic [AW:0]      rd_nxt;
   logic             do_push;
   logic             do_pop;

   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;
   assign wr_nxt   = wr_ptr + (AW+1)'(do_push);
   assign rd_nxt   = rd_ptr + (AW+1)'(do_pop);
   assign pop_data = mem[rd_ptr[AW-1:0]];

   // Extra MSB on each pointer tells a full ring from an empty one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         wr_ptr <= wr_nxt;
         rd_ptr <= rd_nxt;
         full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
         empty  <= (wr_nxt == rd_nxt);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-buffered UART transmitter with configurable framing.
//   clock             in   system clock, rising edge
//   reset             in   asynchronous, active-low
//   read_data         in   DATA_BITS word to queue
//   read_clock_enable in   write strobe, accepted when ready=1
//   ready             out  FIFO can accept a word
//   tx                out  serial line, idle high
//   uart_clock        out  one-cycle strobe on the last cycle of each bit on the line
//   busy              out  frame in progress or FIFO non-empty
//   overflow          out  sticky: write attempted while ready=0
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_FREQ = 12_000_000,
   parameter int unsigned BAUD_RATE  = 115_200,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] read_data,
   input  logic                 read_clock_enable,
   output logic                 ready,
   output logic                 tx,
   output logic                 uart_clock,
   output logic                 busy,
   output logic                 overflow
);

   localparam int unsigned      DIVISOR   = baud_divisor(CLOCK_FREQ, BAUD_RATE);
   localparam int unsigned      DIV_W     = clog2(DIVISOR);
   localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIVISOR - 1);
   localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

   if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx_buffered: CLOCK_FREQ/BAUD_RATE must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_tx_buffered: DATA_BITS must be 5..9");
   end
   if (PARITY > PARITY_ODD) begin : g_bad_parity
      $error("uart_tx_buffered: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_buffered: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_buffered: FIFO_DEPTH must be a power of two >= 2");
   end

   tx_state_t            state;
   tx_state_t            state_nxt;
   logic [DIV_W-1:0]     div_cnt;
   logic [3:0]           bit_cnt;
   logic [DATA_BITS-1:0] shreg;
   logic                 parity_bit;
   logic                 bit_tick;
   logic                 armed;
   logic                 tx_d;
   logic                 uclk_d;
   logic                 fifo_push;
   logic                 fifo_pop;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic [DATA_BITS-1:0] fifo_rd;

   assign ready     = armed & ~fifo_full;
   assign fifo_push = read_clock_enable & ready;
   assign busy      = (state != ST_IDLE) | ~fifo_empty;
   assign bit_tick  = (div_cnt == DIV_LAST);

   uart_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (read_data),
      .pop       (fifo_pop),
      .pop_data  (fifo_rd),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Popping straight out of the last stop bit gives back-to-back frames.
   always_comb begin
      state_nxt = state;
      fifo_pop  = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_nxt = ST_START;
               fifo_pop  = 1'b1;
            end
         end
         ST_START: begin
            if (bit_tick) state_nxt = ST_DATA;
         end
         ST_DATA: begin
            if (bit_tick && bit_cnt == DATA_LAST) begin
               state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end
         end
         ST_PARITY: begin
            if (bit_tick) state_nxt = ST_STOP;
         end
         ST_STOP: begin
            if (bit_tick && bit_cnt == STOP_LAST) begin
               if (!fifo_empty) begin
                  state_nxt = ST_START;
                  fifo_pop  = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         parity_bit <= 1'b0;
      end else if (fifo_pop) begin
         div_cnt    <= '0;
         bit_cnt    <= '0;
         shreg      <= fifo_rd;
         parity_bit <= (^fifo_rd) ^ (PARITY == PARITY_ODD);
      end else if (state == ST_IDLE) begin
         div_cnt <= '0;
      end else if (bit_tick) begin
         div_cnt <= '0;
         if (state == ST_DATA) begin
            shreg   <= shreg >> 1;
            bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 4'd1;
         end else if (state == ST_STOP) begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end else begin
         div_cnt <= div_cnt + DIV_W'(1);
      end
   end

   always_comb begin
      tx_d   = 1'b1;
      uclk_d = 1'b0;
      unique case (state)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shreg[0];
         ST_PARITY: tx_d = parity_bit;
         default:   tx_d = 1'b1;
      endcase
      uclk_d = (state != ST_IDLE) && bit_tick;
   end

   // Line outputs are retimed one clock behind the FSM, so the start bit
   // appears two edges after the accepting write and uart_clock stays
   // aligned with the last cycle of each bit as seen on tx.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         tx         <= 1'b1;
         uart_clock <= 1'b0;
         armed      <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         tx         <= tx_d;
         uart_clock <= uclk_d;
         armed      <= 1'b1;
         overflow   <= overflow | (read_clock_enable & ~ready);
      end
   end

endmodule

// File: tb/tb_uart_tx_buffered.sv
module tb_uart_tx_buffered;

   typedef struct {
      logic [15:0] bits;
      int unsigned len;
      bit          contig;
      bit          abort;
   } frame_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst0;
   logic       rst_all;
   logic [3:0] we;
   logic [7:0] wd0, wd1, wd2;
   logic [4:0] wd3;
   logic [3:0] tx_w, uc_w, rdy_w, busy_w, ovf_w;
   logic [3:0] rst_w;
   assign rst_w = {rst_all, rst_all, rst_all, rst0};

   int     checks = 0;
   int     errors = 0;
   frame_t exp_q [4][$];
   bit     in_frame [4];
   int unsigned last_end [4];

   // dut0: 8N1, dut1: 8E1, dut2: 8O2, dut3: 5N1; all DIVISOR = 8
   uart_tx_buffered #(.CLOCK_FREQ(9600), .BAUD_RATE(1200), .DATA_BITS(8), .PARITY(0),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) dut0 (
      .clock(clk), .reset(rst0), .read_data(wd0), .read_clock_enable(we[0]),
      .ready(rdy_w[0]), .tx(tx_w[0]), .uart_clock(uc_w[0]), .busy(busy_w[0]), .overflow(ovf_w[0]));
   uart_tx_buffered #(.CLOCK_FREQ(9600), .BAUD_RATE(1200), .DATA_BITS(8), .PARITY(1),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) dut1 (
      .clock(clk), .reset(rst_all), .read_data(wd1), .read_clock_enable(we[1]),
      .ready(rdy_w[1]), .tx(tx_w[1]), .uart_clock(uc_w[1]), .busy(busy_w[1]), .overflow(ovf_w[1]));
   uart_tx_buffered #(.CLOCK_FREQ(9600), .BAUD_RATE(1200), .DATA_BITS(8), .PARITY(2),
                      .STOP_BITS(2), .FIFO_DEPTH(16)) dut2 (
      .clock(clk), .reset(rst_all), .read_data(wd2), .read_clock_enable(we[2]),
      .ready(rdy_w[2]), .tx(tx_w[2]), .uart_clock(uc_w[2]), .busy(busy_w[2]), .overflow(ovf_w[2]));
   uart_tx_buffered #(.CLOCK_FREQ(9600), .BAUD_RATE(1200), .DATA_BITS(5), .PARITY(0),
                      .STOP_BITS(1), .FIFO_DEPTH(16)) dut3 (
      .clock(clk), .reset(rst_all), .read_data(wd3), .read_clock_enable(we[3]),
      .ready(rdy_w[3]), .tx(tx_w[3]), .uart_clock(uc_w[3]), .busy(busy_w[3]), .overflow(ovf_w[3]));

   task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d got %0h expected %0h", name, d, act, exp);
      end
   endtask

   function automatic frame_t fr(input logic [15:0] bits, input int unsigned len,
                                 input bit contig, input bit abort);
      frame_t f;
      f.bits = bits; f.len = len; f.contig = contig; f.abort = abort;
      return f;
   endfunction

   // Line bits in time order: bit 0 = start, then data LSB first, parity, stops.
   function automatic frame_t mk(input logic [8:0] data, input int unsigned nb,
                                 input int unsigned par, input int unsigned stp, input bit contig);
      frame_t f;
      logic p;
      int unsigned k;
      f.bits = '0; f.contig = contig; f.abort = 1'b0;
      p = 1'b0;
      k = 1;
      for (int unsigned i = 0; i < nb; i++) begin
         f.bits[k] = data[i];
         p = p ^ data[i];
         k++;
      end
      if (par != 0) begin
         f.bits[k] = (par == 2) ? ~p : p;
         k++;
      end
      for (int unsigned i = 0; i < stp; i++) begin
         f.bits[k] = 1'b1;
         k++;
      end
      f.len = k;
      return f;
   endfunction

   task automatic monitor(input int d);
      frame_t      e;
      logic [15:0] got;
      int unsigned start, unstable, pulses, misplaced;
      bit          aborted, have;
      @(negedge clk);
      forever begin
         if (rst_w[d] === 1'b1 && tx_w[d] === 1'b0) begin
            start = cyc;
            in_frame[d] = 1'b1;
            have = (exp_q[d].size() != 0);
            chk("frame_expected", d, 32'(have), 32'd1);
            if (have) e = exp_q[d].pop_front();
            else e = fr(16'h0, 10, 1'b0, 1'b0);
            got = '0; unstable = 0; pulses = 0; misplaced = 0; aborted = 1'b0;
            for (int unsigned b = 0; b < e.len && !aborted; b++) begin
               for (int unsigned c = 0; c < 8 && !aborted; c++) begin
                  if (rst_w[d] !== 1'b1) begin
                     aborted = 1'b1;
                  end else begin
                     if (c == 0) got[b] = tx_w[d];
                     else if (tx_w[d] !== got[b]) unstable++;
                     if (uc_w[d] === 1'b1) begin
                        pulses++;
                        if (c != 7) misplaced++;
                     end
                     @(negedge clk);
                  end
               end
            end
            chk("abort", d, 32'(aborted), 32'(e.abort));
            if (!e.abort && !aborted) begin
               chk("frame_bits", d, 32'(got), 32'(e.bits));
               chk("bit_stable", d, unstable, 0);
               chk("uclk_pulses", d, pulses, e.len);
               chk("uclk_place", d, misplaced, 0);
               if (e.contig) chk("b2b_gap", d, start - last_end[d], 0);
            end
            last_end[d] = cyc;
            in_frame[d] = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);
   initial monitor(2);
   initial monitor(3);

   task automatic send(input int d, input logic [8:0] data, input bit expect_it, input frame_t f);
      if (expect_it) exp_q[d].push_back(f);
      @(negedge clk);
      case (d)
         0: wd0 = data[7:0];
         1: wd1 = data[7:0];
         2: wd2 = data[7:0];
         default: wd3 = data[4:0];
      endcase
      we[d] = 1'b1;
      @(posedge clk);
      #1 we[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d, input int unsigned budget);
      int unsigned n;
      n = 0;
      while ((exp_q[d].size() != 0 || in_frame[d]) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("drain_in_time", d, 32'(exp_q[d].size() == 0 && !in_frame[d]), 32'd1);
   endtask

   task automatic wait_tx_low(input int d, input int unsigned budget);
      int unsigned n;
      n = 0;
      while (tx_w[d] !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk("start_seen", d, 32'(tx_w[d]), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog dut0 got timeout expected finish");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst0 = 1'b0; rst_all = 1'b0;
      we = '0; wd0 = 8'hFF; wd1 = '0; wd2 = '0; wd3 = '0;
      we[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 4; d++) chk("rst_tx", d, 32'(tx_w[d]), 32'd1);
      chk("rst_ready", 0, 32'(rdy_w[0]), 32'd0);
      chk("rst_busy", 0, 32'(busy_w[0]), 32'd0);
      chk("rst_ovf", 0, 32'(ovf_w[0]), 32'd0);
      chk("rst_uclk", 0, 32'(uc_w[0]), 32'd0);
      @(negedge clk);
      rst0 = 1'b1; rst_all = 1'b1; we[0] = 1'b0;
      #1 chk("ready_pre_edge", 0, 32'(rdy_w[0]), 32'd0);
      @(posedge clk);
      #1 chk("ready_after_edge", 0, 32'(rdy_w[0]), 32'd1);
      chk("busy_no_push", 0, 32'(busy_w[0]), 32'd0);

      // 8N1 0xB7: 0, 1,1,1,0,1,1,0,1, 1 -> 0x36E over 10 bits
      send(0, 9'h0B7, 1'b1, fr(16'h036E, 10, 1'b0, 1'b0));
      chk("busy_after_write", 0, 32'(busy_w[0]), 32'd1);
      @(posedge clk);
      #1 chk("latency_edge1_tx", 0, 32'(tx_w[0]), 32'd1);
      @(posedge clk);
      #1 chk("latency_edge2_tx", 0, 32'(tx_w[0]), 32'd0);
      wait_idle(0, 200);
      repeat (2) @(negedge clk);
      chk("busy_done", 0, 32'(busy_w[0]), 32'd0);

      // 0xB7 has six ones: even parity 0, odd parity 1
      send(1, 9'h0B7, 1'b1, fr(16'h056E, 11, 1'b0, 1'b0));
      send(2, 9'h0B7, 1'b1, fr(16'h0F6E, 12, 1'b0, 1'b0));
      // 5N1 0x1F: 0, 1,1,1,1,1, 1 -> 0x7E over 7 bits
      send(3, 9'h01F, 1'b1, fr(16'h007E, 7, 1'b0, 1'b0));
      wait_idle(1, 300);
      wait_idle(2, 300);
      wait_idle(3, 300);

      // Burst while a frame is on the line, so nothing pops during the fill.
      send(0, 9'h096, 1'b1, mk(9'h096, 8, 0, 1, 1'b0));
      wait_tx_low(0, 20);
      for (int i = 0; i < 16; i++) exp_q[0].push_back(mk(9'(i * 29 + 3), 8, 0, 1, 1'b1));
      @(negedge clk);
      we[0] = 1'b1;
      wd0 = 8'(3);
      for (int i = 0; i < 17; i++) begin
         @(posedge clk);
         #1;
         if (i == 14) chk("ready_before_full", 0, 32'(rdy_w[0]), 32'd1);
         if (i == 15) begin
            chk("ready_full", 0, 32'(rdy_w[0]), 32'd0);
            chk("ovf_not_yet", 0, 32'(ovf_w[0]), 32'd0);
         end
         if (i == 16) chk("ovf_set", 0, 32'(ovf_w[0]), 32'd1);
         wd0 = 8'((i + 1) * 29 + 3);
      end
      we[0] = 1'b0;
      wait_idle(0, 2000);
      repeat (100) @(negedge clk);
      chk("burst_busy_done", 0, 32'(busy_w[0]), 32'd0);
      chk("ovf_sticky", 0, 32'(ovf_w[0]), 32'd1);

      // Reset in data bit 0 of 0x5A (a zero) with a second word still queued.
      send(0, 9'h05A, 1'b1, fr(16'h0, 10, 1'b0, 1'b1));
      send(0, 9'h0C3, 1'b0, fr(16'h0, 10, 1'b0, 1'b0));
      wait_tx_low(0, 20);
      repeat (12) @(negedge clk);
      chk("pre_rst_tx", 0, 32'(tx_w[0]), 32'd0);
      #2 rst0 = 1'b0;
      #1;
      chk("mid_rst_tx", 0, 32'(tx_w[0]), 32'd1);
      chk("mid_rst_busy", 0, 32'(busy_w[0]), 32'd0);
      chk("mid_rst_ready", 0, 32'(rdy_w[0]), 32'd0);
      chk("mid_rst_ovf", 0, 32'(ovf_w[0]), 32'd0);
      repeat (3) @(negedge clk);
      rst0 = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_mid_rst", 0, 32'(rdy_w[0]), 32'd1);
      chk("busy_after_mid_rst", 0, 32'(busy_w[0]), 32'd0);
      send(0, 9'h03C, 1'b1, mk(9'h03C, 8, 0, 1, 1'b0));
      wait_idle(0, 200);
      repeat (100) @(negedge clk);
      chk("final_busy", 0, 32'(busy_w[0]), 32'd0);

      for (int d = 0; d < 4; d++) chk("queue_empty", d, 32'(exp_q[d].size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
